router_pkt_tx: RTL and testbench
================================

# router_pkt_tx

Packet source for the 1x3 router input port. It accepts a transmit command (destination, payload length) and a payload byte stream, and buffers the whole payload internally. It then drives header, payload and parity onto the router's pkt_valid/data_in interface, honouring busy. Finally it watches the router's error flag to report per-packet status. It sits between the test/host logic and the router's source side, so the router always sees a continuous, protocol-correct packet.

## Interface
- ERR_WAIT, 4: cycles after the parity byte during which router error is monitored (1..15).
- MAX_LEN, 63: payload buffer depth in bytes; fixed by the 6-bit length field.

- clock  input  1  single clock; all logic on posedge.
- resetn  input  1  reset, asynchronous, active-low.
- start  input  1  command strobe; accepted when tx_ready=1.
- dest  input  2  destination port 0..2; 3 is illegal.
- len  input  6  payload length 1..63; 0 is illegal.
- tx_ready  output  1  block idle, can accept start.
- pld_data  input  8  payload byte.
- pld_valid  input  1  payload byte present.
- pld_ready  output  1  block accepting payload bytes.
- busy  input  1  router busy; hold outputs.
- error  input  1  router parity-error indication.
- pkt_valid  output  1  to router; high for header and payload bytes.
- data_in  output  8  to router data input.
- done  output  1  one-cycle pulse at end of packet.
- pkt_err  output  1  router error seen for this packet; valid only while done=1.
- cmd_err  output  1  one-cycle pulse when an illegal command is rejected.

## Operation
- States: IDLE, LOAD, HEADER, PAYLOAD, PARITY, CHECK.
- IDLE: tx_ready=1. On start, latch dest and len.
  - If dest==3 or len==0: pulse cmd_err for the next cycle and stay in IDLE.
  - Otherwise: header = {len, dest}, parity accumulator = header, go to LOAD.
- LOAD: pld_ready=1. On each pld_valid&pld_ready:
  - Store the byte at index cnt, XOR it into parity, increment cnt.
  - On acceptance of the len-th byte, go to HEADER. cnt never exceeds len-1 and never wraps.
- HEADER: pkt_valid=1, data_in=header.
- PAYLOAD: pkt_valid=1, data_in=buf[idx] for idx 0..len-1, in the order loaded.
- PARITY: pkt_valid=0, data_in=parity.
- CHECK: pkt_valid=0, data_in=0.
  - Run ERR_WAIT cycles; any posedge with error=1 sets the sticky err flag.
  - Then return to IDLE, pulsing done with pkt_err=err flag. The err flag clears on entry to HEADER.
- Busy rule: in HEADER, PAYLOAD and PARITY, a posedge with busy=1 leaves pkt_valid, data_in and state unchanged. A posedge with busy=0 advances to the next byte or state.
- start asserted outside IDLE is ignored. pld_valid outside LOAD is ignored.
- Reset (asynchronous) returns the block to IDLE and discards buffer, counters and flags.
  - Reset values: pkt_valid=0, data_in=0, pld_ready=0, done=0, pkt_err=0, cmd_err=0, tx_ready=1.

## Timing
- pkt_valid and data_in are registered. HEADER appears on the cycle after the last payload byte is accepted.
- With busy=0 throughout:
  - pkt_valid is high for exactly len+1 consecutive cycles.
  - The parity byte follows immediately for 1 cycle.
  - CHECK lasts ERR_WAIT cycles.
  - done rises the cycle after CHECK ends.
- Command to first load slot: 1 cycle. Total latency from start to done, with no stalls, is 1 + len + (len+2) + ERR_WAIT cycles.
- Holding busy=1 for N posedges stretches the current byte by exactly N cycles. data_in never changes on a cycle following busy=1.
- tx_ready returns to 1 the cycle after done. Back-to-back start on that cycle is accepted.
- Reset asserted mid-packet: pkt_valid drops to 0 asynchronously, with no parity byte sent.

## Configuration
- ROUTER_TX_CORRUPT_EN defined: adds input port inject_err (1 bit), sampled with start. When it is 1, the transmitted parity byte has bit 0 inverted; the stored accumulator stays correct.
- ROUTER_TX_CORRUPT_EN undefined: inject_err is absent and parity is always correct.

## Test plan
- Basic packet:
  - Stimulus: dest=1, len=3, payload 0xA1,0xB2,0xC3, busy=0.
  - Response: data_in 0x0D,0xA1,0xB2,0xC3 with pkt_valid=1, then parity 0xDD with pkt_valid=0. done after 4 CHECK cycles, pkt_err=0.
- Busy stall:
  - Stimulus: same packet, busy=1 for 2 posedges while the header is driven.
  - Response: 0x0D is held for 3 cycles, the rest of the sequence is unchanged, and data_in never changes after a busy=1 edge.
- Illegal command:
  - Stimulus: dest=3, len=5.
  - Response: cmd_err pulses once, pld_ready stays 0, tx_ready stays 1.
- Maximum length:
  - Stimulus: len=63 with pld_valid deasserted every other cycle.
  - Response: header 0xFC (dest=0), all 63 bytes sent in order, correct XOR parity, pkt_valid high for 64 cycles.
- Router error:
  - Stimulus: error=1 on the 2nd CHECK cycle.
  - Response: done with pkt_err=1. The next clean packet reports pkt_err=0.
- Reset mid-packet:
  - Stimulus: resetn low during the 2nd payload byte.
  - Response: all outputs go to their reset values immediately. A following dest=2, len=1 packet completes normally.

Source files
------------

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers a command's payload, then sends header/payload/parity to the router
// and reports the router error flag per packet. Define ROUTER_TX_CORRUPT_EN to add inject_err.
module router_pkt_tx #(
  parameter int ERR_WAIT = 4,
  parameter int MAX_LEN  = 63
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [1:0] dest,
  input  logic [5:0] len,
`ifdef ROUTER_TX_CORRUPT_EN
  input  logic       inject_err,
`endif
  output logic       tx_ready,
  input  logic [7:0] pld_data,
  input  logic       pld_valid,
  output logic       pld_ready,
  input  logic       busy,
  input  logic       error,
  output logic       pkt_valid,
  output logic [7:0] data_in,
  output logic       done,
  output logic       pkt_err,
  output logic       cmd_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_HEADER  = 3'd2,
    S_PAYLOAD = 3'd3,
    S_PARITY  = 3'd4,
    S_CHECK   = 3'd5
  } state_t;

  localparam logic [5:0] CHK_LAST = 6'(ERR_WAIT - 1);

  function automatic logic [7:0] parity_acc(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t     state_r, state_nxt_s;
  logic [5:0] cnt_r, cnt_nxt_s;
  logic [1:0] dest_r;
  logic [5:0] len_r;
  logic [7:0] parity_r;
  logic       inj_r, err_r, inject_s;
  logic [7:0] buf_r [0:MAX_LEN-1];
  logic       cmd_ok_s, cmd_bad_s, take_s;
  logic       pkt_valid_nxt_s, pld_ready_nxt_s, tx_ready_nxt_s;
  logic       done_nxt_s, pkt_err_nxt_s, cmd_err_nxt_s;
  logic [7:0] data_nxt_s;

`ifdef ROUTER_TX_CORRUPT_EN
  assign inject_s = inject_err;
`else
  assign inject_s = 1'b0;
`endif

  // tx_ready is low on the done cycle, so a start there is not taken
  assign cmd_ok_s  = (state_r == S_IDLE) && tx_ready && start && (dest != 2'd3) && (len != 6'd0);
  assign cmd_bad_s = (state_r == S_IDLE) && tx_ready && start && ((dest == 2'd3) || (len == 6'd0));
  assign take_s    = (state_r == S_LOAD) && pld_valid && pld_ready;

  // State register, shared counter and registered outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r   <= S_IDLE;
      cnt_r     <= 6'd0;
      pkt_valid <= 1'b0;
      data_in   <= 8'd0;
      pld_ready <= 1'b0;
      tx_ready  <= 1'b1;
      done      <= 1'b0;
      pkt_err   <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      pkt_valid <= pkt_valid_nxt_s;
      data_in   <= data_nxt_s;
      pld_ready <= pld_ready_nxt_s;
      tx_ready  <= tx_ready_nxt_s;
      done      <= done_nxt_s;
      pkt_err   <= pkt_err_nxt_s;
      cmd_err   <= cmd_err_nxt_s;
    end
  end

  // Next state; cnt is the load index, then the payload index, then the CHECK timer
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        cnt_nxt_s = 6'd0;
        if (cmd_ok_s) state_nxt_s = S_LOAD;
        else          state_nxt_s = S_IDLE;
      end
      S_LOAD: begin
        if (take_s && (cnt_r == len_r - 6'd1)) begin
          state_nxt_s = S_HEADER;
          cnt_nxt_s   = 6'd0;
        end else if (take_s) begin
          cnt_nxt_s = cnt_r + 6'd1;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      S_HEADER: begin
        if (!busy) state_nxt_s = S_PAYLOAD;
        else       state_nxt_s = S_HEADER;
      end
      S_PAYLOAD: begin
        if (busy) begin
          cnt_nxt_s = cnt_r;
        end else if (cnt_r == len_r - 6'd1) begin
          state_nxt_s = S_PARITY;
          cnt_nxt_s   = 6'd0;
        end else begin
          cnt_nxt_s = cnt_r + 6'd1;
        end
      end
      S_PARITY: begin
        if (!busy) state_nxt_s = S_CHECK;
        else       state_nxt_s = S_PARITY;
      end
      S_CHECK: begin
        if (cnt_r == CHK_LAST) begin
          state_nxt_s = S_IDLE;
          cnt_nxt_s   = 6'd0;
        end else begin
          cnt_nxt_s = cnt_r + 6'd1;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = 6'd0;
      end
    endcase
  end

  // Output values for the next cycle, derived from the next state so they can be registered
  always_comb begin
    pkt_valid_nxt_s = (state_nxt_s == S_HEADER) || (state_nxt_s == S_PAYLOAD);
    pld_ready_nxt_s = (state_nxt_s == S_LOAD);
    done_nxt_s      = (state_r == S_CHECK) && (cnt_r == CHK_LAST);
    pkt_err_nxt_s   = done_nxt_s && (err_r || error);
    tx_ready_nxt_s  = (state_nxt_s == S_IDLE) && !done_nxt_s;
    cmd_err_nxt_s   = cmd_bad_s;
    case (state_nxt_s)
      S_HEADER:  data_nxt_s = {len_r, dest_r};
      S_PAYLOAD: data_nxt_s = buf_r[cnt_nxt_s];
      S_PARITY:  data_nxt_s = parity_r ^ {7'd0, inj_r};
      default:   data_nxt_s = 8'd0;
    endcase
  end

  // Command latch, parity accumulator and sticky router-error flag
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dest_r   <= 2'd0;
      len_r    <= 6'd0;
      parity_r <= 8'd0;
      inj_r    <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      if (cmd_ok_s) begin
        dest_r   <= dest;
        len_r    <= len;
        parity_r <= {len, dest};
        inj_r    <= inject_s;
      end else if (take_s) begin
        parity_r <= parity_acc(parity_r, pld_data);
      end
      if ((state_r == S_LOAD) && (state_nxt_s == S_HEADER)) err_r <= 1'b0;
      else if ((state_r == S_CHECK) && error)              err_r <= 1'b1;
    end
  end

  // Payload store; every entry read for a packet was rewritten during its LOAD phase
  always_ff @(posedge clock) begin
    if (take_s) buf_r[cnt_r] <= pld_data;
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: randomized bench; a per-cycle expected trace is built from the packet
// rules (load, busy-stretched byte list, CHECK window, done) and compared with every output.
module tb_router_pkt_tx;

  localparam int W    = 4;
  localparam int MAXC = 1024;

  logic       clock = 1'b0;
  logic       resetn, start, pld_valid, busy, error;
  logic [1:0] dest;
  logic [5:0] len;
  logic [7:0] pld_data, data_in;
  logic       tx_ready, pld_ready, pkt_valid, done, pkt_err, cmd_err;
`ifdef ROUTER_TX_CORRUPT_EN
  logic       inject_err;
`endif

  int checks = 0;
  int errors = 0;

  bit          pv_a [MAXC];
  bit          bz_a [MAXC];
  bit          er_a [MAXC];
  bit          st_a [MAXC];
  logic [13:0] obs_a [MAXC];
  logic [13:0] exp_a [MAXC];
  logic [7:0]  pay [64];

  router_pkt_tx dut (
    .clock(clock), .resetn(resetn), .start(start), .dest(dest), .len(len),
`ifdef ROUTER_TX_CORRUPT_EN
    .inject_err(inject_err),
`endif
    .tx_ready(tx_ready), .pld_data(pld_data), .pld_valid(pld_valid), .pld_ready(pld_ready),
    .busy(busy), .error(error), .pkt_valid(pkt_valid), .data_in(data_in),
    .done(done), .pkt_err(pkt_err), .cmd_err(cmd_err)
  );

  always #5 clock = ~clock;

  // trace word: {tx_ready, pld_ready, pkt_valid, data_in[7:0], done, pkt_err, cmd_err}
  task automatic drive_idle;
    start = 1'b0; dest = 2'd0; len = 6'd0; pld_valid = 1'b0; pld_data = 8'd0;
    busy = 1'b0; error = 1'b0;
  endtask

  task automatic gen_stim(input int pvp, input int bzp, input int erp, input int stp);
    for (int c = 0; c < MAXC; c++) begin
      pv_a[c] = (int'($urandom_range(99)) < pvp);
      bz_a[c] = (int'($urandom_range(99)) < bzp);
      er_a[c] = (int'($urandom_range(99)) < erp);
      st_a[c] = (int'($urandom_range(99)) < stp);
    end
  endtask

  task automatic fill_pay(input int l);
    for (int i = 0; i < 64; i++) pay[i] = (i < l) ? 8'($urandom) : 8'd0;
  endtask

  // Reference: cycle 0 is the start cycle; returns n, the first cycle with tx_ready back high
  task automatic model(input logic [1:0] d, input logic [5:0] l, input bit inj, output int n);
    int c, acc, k;
    bit ef;
    logic [7:0] par;
    logic [7:0] e[$];
    c = 1; acc = 0;
    while (acc < int'(l) && c < MAXC - 8) begin
      exp_a[c] = {1'b0, 1'b1, 1'b0, 8'd0, 3'b000};
      if (pv_a[c]) acc++;
      c++;
    end
    par = {l, d};
    e.push_back(par);
    for (int i = 0; i < int'(l); i++) begin
      e.push_back(pay[i]);
      par = par ^ pay[i];
    end
    e.push_back(par ^ {7'd0, inj});
    k = 0;
    while (k < int'(l) + 2 && c < MAXC - 8) begin
      exp_a[c] = {2'b00, (k <= int'(l)), e[k], 3'b000};
      if (!bz_a[c]) k++;
      c++;
    end
    ef = 1'b0;
    for (int w = 0; w < W; w++) begin
      exp_a[c] = 14'd0;
      if (er_a[c]) ef = 1'b1;
      c++;
    end
    exp_a[c] = {11'd0, 1'b1, ef, 1'b0};
    c++;
    exp_a[c] = {1'b1, 13'd0};
    n = c;
  endtask

  // Plays stimulus tables for cycles 0..n; payload bytes are presented in order while pld_ready
  task automatic play(input logic [1:0] d, input logic [5:0] l, input bit inj, input int n);
    int ns;
    ns = 0;
    start = 1'b1; dest = d; len = l; pld_valid = pv_a[0]; pld_data = 8'($urandom);
    busy = bz_a[0]; error = er_a[0];
`ifdef ROUTER_TX_CORRUPT_EN
    inject_err = inj;
`endif
    for (int c = 1; c <= n; c++) begin
      @(negedge clock);
      obs_a[c] = {tx_ready, pld_ready, pkt_valid, data_in, done, pkt_err, cmd_err};
      if (c == n) begin
        drive_idle();
      end else begin
        start = st_a[c]; dest = 2'($urandom); len = 6'($urandom);
        pld_valid = pv_a[c]; busy = bz_a[c]; error = er_a[c];
        if (pld_ready && ns < int'(l)) begin
          pld_data = pay[ns];
          if (pv_a[c]) ns++;
        end else begin
          pld_data = 8'($urandom);
        end
      end
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    drive_idle();
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({tx_ready, pld_ready, pkt_valid, data_in, done, pkt_err, cmd_err} !== 14'h2000) begin
      errors++;
      $display("FAIL reset_values got %h exp %h",
               {tx_ready, pld_ready, pkt_valid, data_in, done, pkt_err, cmd_err}, 14'h2000);
    end
    resetn = 1'b1;
  endtask

  task automatic test_basic;
    int n;
    gen_stim(100, 0, 0, 0);
    fill_pay(3);
    pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
    model(2'd1, 6'd3, 1'b0, n);
    play(2'd1, 6'd3, 1'b0, n);
    for (int c = 1; c <= n; c++) begin
      checks++;
      if (obs_a[c] !== exp_a[c]) begin
        errors++;
        $display("FAIL basic_trace cyc %0d got %h exp %h", c, obs_a[c], exp_a[c]);
      end
    end
    checks++;
    if (obs_a[4][10:3] !== 8'h0D || obs_a[8][10:3] !== 8'hDD || obs_a[13][2] !== 1'b1) begin
      errors++;
      $display("FAIL basic_bytes hdr %h par %h done@13 %b exp 0d dd 1",
               obs_a[4][10:3], obs_a[8][10:3], obs_a[13][2]);
    end
  endtask

  task automatic test_busy;
    int n;
    logic [1:0] d;
    logic [5:0] l;
    gen_stim(100, 0, 0, 0);
    bz_a[4] = 1'b1; bz_a[5] = 1'b1;
    fill_pay(3);
    pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
    model(2'd1, 6'd3, 1'b0, n);
    play(2'd1, 6'd3, 1'b0, n);
    for (int c = 1; c <= n; c++) begin
      checks++;
      if (obs_a[c] !== exp_a[c]) begin
        errors++;
        $display("FAIL busy_trace cyc %0d got %h exp %h", c, obs_a[c], exp_a[c]);
      end
    end
    checks++;
    if (obs_a[6][10:3] !== 8'h0D || obs_a[7][10:3] !== 8'hA1) begin
      errors++;
      $display("FAIL busy_hold cyc6 %h cyc7 %h exp 0d a1", obs_a[6][10:3], obs_a[7][10:3]);
    end
    for (int p = 0; p < 2; p++) begin
      gen_stim(75, 35, 0, 10);
      d = 2'($urandom_range(2));
      l = 6'($urandom_range(40, 1));
      fill_pay(int'(l));
      model(d, l, 1'b0, n);
      play(d, l, 1'b0, n);
      for (int c = 1; c <= n; c++) begin
        checks++;
        if (obs_a[c] !== exp_a[c]) begin
          errors++;
          $display("FAIL busy_rand%0d cyc %0d got %h exp %h", p, c, obs_a[c], exp_a[c]);
        end
      end
    end
  endtask

  task automatic test_illegal;
    logic [13:0] o;
    for (int t = 0; t < 2; t++) begin
      @(negedge clock);
      start = 1'b1;
      dest  = (t == 0) ? 2'd3 : 2'($urandom_range(2));
      len   = (t == 0) ? 6'd5 : 6'd0;
      for (int c = 1; c <= 3; c++) begin
        @(negedge clock);
        drive_idle();
        o = {tx_ready, pld_ready, pkt_valid, data_in, done, pkt_err, cmd_err};
        checks++;
        if (o !== ((c == 1) ? 14'h2001 : 14'h2000)) begin
          errors++;
          $display("FAIL illegal%0d cyc %0d got %h exp %h", t, c, o,
                   (c == 1) ? 14'h2001 : 14'h2000);
        end
      end
    end
  endtask

  task automatic test_max_len;
    int n, hdr_c, nv;
    gen_stim(0, 0, 0, 0);
    for (int c = 0; c < MAXC; c++) pv_a[c] = (c % 2 == 1);
    fill_pay(63);
    model(2'd0, 6'd63, 1'b0, n);
    play(2'd0, 6'd63, 1'b0, n);
    hdr_c = 0; nv = 0;
    for (int c = 1; c <= n; c++) begin
      checks++;
      if (obs_a[c] !== exp_a[c]) begin
        errors++;
        $display("FAIL maxlen_trace cyc %0d got %h exp %h", c, obs_a[c], exp_a[c]);
      end
      if (exp_a[c][11] && hdr_c == 0) hdr_c = c;
      if (obs_a[c][11] === 1'b1) nv++;
    end
    checks++;
    if (obs_a[hdr_c][10:3] !== 8'hFC || nv != 64) begin
      errors++;
      $display("FAIL maxlen_hdr hdr %h valid_cycles %0d exp fc 64", obs_a[hdr_c][10:3], nv);
    end
  endtask

  task automatic test_router_error;
    int n;
    logic [5:0] l;
    for (int p = 0; p < 2; p++) begin
      gen_stim(100, 0, 0, 0);
      l = 6'($urandom_range(8, 1));
      if (p == 0) er_a[2 * int'(l) + 4] = 1'b1;
      fill_pay(int'(l));
      model(2'd2, l, 1'b0, n);
      play(2'd2, l, 1'b0, n);
      for (int c = 1; c <= n; c++) begin
        checks++;
        if (obs_a[c] !== exp_a[c]) begin
          errors++;
          $display("FAIL rerr%0d_trace cyc %0d got %h exp %h", p, c, obs_a[c], exp_a[c]);
        end
      end
      checks++;
      if (obs_a[n-1][2:1] !== ((p == 0) ? 2'b11 : 2'b10)) begin
        errors++;
        $display("FAIL rerr%0d_status done/pkt_err %b exp %b", p, obs_a[n-1][2:1],
                 (p == 0) ? 2'b11 : 2'b10);
      end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    logic [5:0] l;
    logic [13:0] o;
    gen_stim(100, 0, 0, 0);
    l = 6'($urandom_range(10, 3));
    fill_pay(int'(l));
    model(2'd1, l, 1'b0, n);
    play(2'd1, l, 1'b0, int'(l) + 3);
    for (int c = 1; c <= int'(l) + 3; c++) begin
      checks++;
      if (obs_a[c] !== exp_a[c]) begin
        errors++;
        $display("FAIL midrst_pre cyc %0d got %h exp %h", c, obs_a[c], exp_a[c]);
      end
    end
    checks++;
    if (obs_a[int'(l) + 3][11:3] !== {1'b1, pay[1]}) begin
      errors++;
      $display("FAIL midrst_byte2 got %h exp %h", obs_a[int'(l) + 3][11:3], {1'b1, pay[1]});
    end
    #2 resetn = 1'b0;
    #1 o = {tx_ready, pld_ready, pkt_valid, data_in, done, pkt_err, cmd_err};
    checks++;
    if (o !== 14'h2000) begin
      errors++;
      $display("FAIL midrst_async got %h exp %h", o, 14'h2000);
    end
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    gen_stim(100, 0, 0, 0);
    fill_pay(1);
    model(2'd2, 6'd1, 1'b0, n);
    play(2'd2, 6'd1, 1'b0, n);
    for (int c = 1; c <= n; c++) begin
      checks++;
      if (obs_a[c] !== exp_a[c]) begin
        errors++;
        $display("FAIL midrst_after cyc %0d got %h exp %h", c, obs_a[c], exp_a[c]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n;
    logic [1:0] d;
    logic [5:0] l;
    bit inj;
    for (int p = 0; p < 8; p++) begin
      gen_stim(70, 25, 10, 10);
      d = 2'($urandom_range(2));
      l = 6'($urandom_range(63, 1));
`ifdef ROUTER_TX_CORRUPT_EN
      inj = 1'($urandom_range(1));
`else
      inj = 1'b0;
`endif
      fill_pay(int'(l));
      model(d, l, inj, n);
      play(d, l, inj, n);
      for (int c = 1; c <= n; c++) begin
        checks++;
        if (obs_a[c] !== exp_a[c]) begin
          errors++;
          $display("FAIL b2b%0d cyc %0d got %h exp %h", p, c, obs_a[c], exp_a[c]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    @(negedge clock);
    test_basic();
    test_busy();
    test_illegal();
    @(negedge clock);
    test_max_len();
    test_router_error();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
